mult_table_scheduler: RTL

- Time-shares one iterative multiplication-table datapath (index counter plus accumulator) among NREQ requesters.
- Each requester supplies a multiplicand.
- The block arbitrates round-robin, then streams index/result pairs 1..LAST_IDX for the granted requester over a valid/ready output.
- Sits between table consumers (display/log units) and the table generator role.

---
 rtl/mult_table_scheduler_pkg.sv | 25 ++
 rtl/mult_table_scheduler_rr_arbiter.sv | 44 ++++
 rtl/mult_table_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mult_table_scheduler_pkg.sv
// Shared types and constants for the multiplication-table scheduler family.
//   state_e   : scheduler FSM states (IDLE, LOAD, RUN, DONE)
//   DEF_*     : default widths / table length
//   id_width  : width of a binary requester id (at least one bit)
package mult_table_pkg;

  localparam int DEF_NREQ     = 2;
  localparam int DEF_MULT_W   = 4;
  localparam int DEF_IDX_W    = 4;
  localparam int DEF_RES_W    = 8;
  localparam int DEF_LAST_IDX = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // A single requester still needs a one-bit id port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_table_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req  : request vector
//   ptr  : highest-priority requester id
//   gnt  : one-hot grant (zero when no request)
//   id   : binary id of the granted requester
//   any  : at least one request present
module rr_arbiter
  import mult_table_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] id,
  output logic            any
);

  always_comb begin
    // NOTE: every output gets a default before the search, so no path leaves
    // a value unassigned and no latch is inferred.
    gnt = '0;
    id  = '0;
    any = 1'b0;
    // First pass scans ptr..NREQ-1, second pass wraps to 0..ptr-1; this gives
    // cyclic priority without a modulo on the index.
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (ID_W'(i) >= ptr)) begin
        gnt[i] = 1'b1;
        id     = ID_W'(i);
        any    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (ID_W'(i) < ptr)) begin
        gnt[i] = 1'b1;
        id     = ID_W'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_table_scheduler.sv
// Time-shares one iterative multiplication-table datapath among NREQ
// requesters. A round-robin winner gets its table streamed as index/result
// pairs 1..LAST_IDX over a valid/ready interface.
//   clk, reset            : clock (rising edge), async active-low reset
//   req, req_mult         : per-requester level request and packed multiplicand
//   abort                 : end the running table early (RUN only)
//   grant, out_owner      : one-hot and binary owner of the datapath
//   busy                  : scheduler not idle
//   out_valid/out_ready   : pair handshake; out_index, out_result carry the pair
//   done, aborted         : one-cycle end-of-table pulse and its abort flag
//   overflow              : sticky per table, some result wrapped past RES_W
module mult_table_scheduler
  import mult_table_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int MULT_W   = DEF_MULT_W,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int RES_W    = DEF_RES_W,
  parameter int LAST_IDX = DEF_LAST_IDX
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*MULT_W-1:0]    req_mult,
  input  logic                      abort,
  output logic [NREQ-1:0]           grant,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_index,
  output logic [RES_W-1:0]          out_result,
  output logic [id_width(NREQ)-1:0] out_owner,
  output logic                      done,
  output logic                      aborted,
  output logic                      overflow
);

  localparam int OWN_W = id_width(NREQ);
  localparam int ACC_W = RES_W + 1;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   ptr_q, ptr_d;
  logic [MULT_W-1:0]  mult_q, mult_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               abt_q, abt_d;

  logic [NREQ-1:0]    arb_gnt;
  logic [OWN_W-1:0]   arb_id;
  logic               arb_any;
  logic [MULT_W-1:0]  owner_mult;
  logic [ACC_W-1:0]   sum;
  logic               handshake;
  logic               last_pair;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (OWN_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .id  (arb_id),
    .any (arb_any)
  );

  assign owner_mult = req_mult[int'(owner_q)*MULT_W +: MULT_W];
  // One extra bit catches the carry out of the truncated running result.
  assign sum        = {1'b0, acc_q} + ACC_W'(mult_q);
  assign handshake  = (state_q == ST_RUN) && out_ready;
  assign last_pair  = (index_q == IDX_W'(LAST_IDX));

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: flops take <= so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (arb_any) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (abort || (handshake && last_pair)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q != ST_IDLE);
    out_valid  = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    aborted    = (state_q == ST_DONE) && abt_q;
    grant      = grant_q;
    out_owner  = owner_q;
    out_index  = index_q;
    out_result = acc_q;
    overflow   = ovf_q;
  end

  // Datapath and ownership next values
  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    mult_d  = mult_q;
    index_d = index_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    abt_d   = abt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          owner_d = arb_id;
        end
      end
      ST_LOAD: begin
        mult_d  = owner_mult;
        index_d = IDX_W'(1);
        acc_d   = RES_W'(owner_mult);
        ovf_d   = 1'b0;
        abt_d   = 1'b0;
      end
      ST_RUN: begin
        // Abort wins over advancing; a pair handshaken alongside it is simply consumed.
        if (abort) begin
          abt_d = 1'b1;
        end else if (handshake && !last_pair) begin
          index_d = index_q + IDX_W'(1);
          acc_d   = sum[RES_W-1:0];
          ovf_d   = ovf_q | sum[RES_W];
        end
      end
      ST_DONE: begin
        grant_d = '0;
        ptr_d   = (owner_q == OWN_W'(NREQ - 1)) ? '0 : owner_q + OWN_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      mult_q  <= '0;
      index_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      mult_q  <= mult_d;
      index_q <= index_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      abt_q   <= abt_d;
    end
  end

endmodule
